stage_sequence_checker: RTL and testbench
=========================================

Name: stage_sequence_checker

Overview:
- Sits beside the stage controller and monitors its strobe outputs: pc_wren, wb_if_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren and stage_reset_n.
- Tracks the expected multi-cycle stage sequence, counts retired instructions, and latches the first protocol violation with its code and stage.
- Used in simulation and on-board debug. Non-intrusive: it drives nothing back into the datapath.

Parameters:
- CNT_W, 32, width of retired_count and cycle_count.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- stage_reset_n  in  1  controller stage reset (0 = controller in INIT)
- pc_wren  in  1  observed strobe
- wb_if_wren  in  1  observed strobe
- if_id_wren  in  1  observed strobe
- id_ex_wren  in  1  observed strobe
- ex_mem_wren  in  1  observed strobe
- mem_wb_wren  in  1  observed strobe
- ram_wren  in  1  observed strobe
- reg_wren  in  1  observed strobe
- err_clear  in  1  clears sticky error and forces resync
- in_sync  out  1  checker is locked to the sequence
- instr_done  out  1  one-cycle pulse per legally completed instruction
- retired_count  out  CNT_W  completed instructions, wraps modulo 2^CNT_W
- cycle_count  out  CNT_W  clk cycles while in_sync, wraps
- err_valid  out  1  sticky error flag
- err_code  out  3  first error code
- err_stage  out  4  expected stage when the error occurred

Behaviour:
- Reset (reset_n=0 at posedge): all outputs 0; FSM in S_UNSYNC.
- Inputs are sampled at each posedge. Every output is registered, so a result is visible the cycle after the offending sample.
- Strobe vector order (bit 7..0): pc, wb_if, if_id, id_ex, ex_mem, mem_wb, ram, reg.
- Expected sequence and required strobe per stage; all other non-pc strobes must be 0:
  - IF: none
  - IF_ID: if_id
  - ID: none
  - ID_EX: id_ex
  - EX_MEM: ex_mem
  - MEM: ram
  - MEM_WB: mem_wb
  - WB: reg
  - WB_IF: wb_if, then back to IF
- pc_wren is legal only in WB_IF (optional there). Anywhere else it is an error.
- S_UNSYNC:
  - in_sync=0, no checks.
  - A sample with stage_reset_n=0 moves the FSM to S_INIT.
- S_INIT:
  - While stage_reset_n=0, all strobes must be 0; otherwise code 1/4/2 applies.
  - The first sample with stage_reset_n=1 is checked as IF, sets in_sync=1, and moves to S_TRACK with expected stage IF_ID.
- S_TRACK: each sample is checked against the expected stage, and the expected stage then advances.
  - A matching WB_IF sample pulses instr_done and increments retired_count in the same update.
- stage_reset_n=0 while in S_TRACK: legal abort. Go to S_INIT, no error, no retire, counters hold.
- Error codes, priority high to low, only the first is recorded:
  - 1: more than one non-pc strobe high
  - 4: pc_wren outside WB_IF
  - 2: a strobe other than the expected one is high
  - 3: the expected strobe is missing
- On an error:
  - Set err_valid=1 and latch err_code and err_stage (stage encoding 1..9 = IF..WB_IF; INIT = 0).
  - Go to S_ERROR with in_sync=0.
  - Counters freeze; err_* hold until reset or err_clear.
- S_ERROR: waits for stage_reset_n=0, then goes to S_INIT (resync). err_valid stays set.
- err_clear=1: clears err_valid, err_code and err_stage to 0 and goes to S_UNSYNC. This takes priority over any simultaneous error detection in that cycle.
- cycle_count increments on every cycle where in_sync=1 at the start of the cycle.

Decomposition:
- Package stage_chk_pkg holds:
  - typedef enum for the expected stage (INIT=0, IF=1 … WB_IF=9)
  - typedef enum for FSM states (S_UNSYNC, S_INIT, S_TRACK, S_ERROR)
  - localparams for the error codes (1..4)
  - strobe bit indices
- One combinational sub-module, stage_strobe_expect: maps the expected stage to the required 8-bit strobe mask and a pc-allowed bit.

Test Plan:
- Reset, stage_reset_n held 0 for 3 cycles, then the legal 9-cycle sequence repeated 4 times -> in_sync=1; 4 instr_done pulses, each 1 cycle after its WB_IF sample; retired_count=4; err_valid=0.
- Legal run, but ram_wren and mem_wb_wren both high in the MEM sample -> err_valid=1, err_code=1, err_stage=6; counters frozen.
- pc_wren=1 during the ID sample -> err_code=4, err_stage=3. Separately, pc_wren=1 during WB_IF -> no error, retire counted.
- reg_wren missing in WB (all strobes 0) -> err_code=3, err_stage=8. Then stage_reset_n=0 for 1 cycle and a legal sequence follows -> in_sync returns to 1, err_valid stays 1.
- stage_reset_n dropped at EX_MEM of the 2nd instruction -> no error; retired_count=1; the next full sequence brings it to 2.
- Error pending, then err_clear=1 in the same cycle as a new violating sample -> err_valid=0, state S_UNSYNC. Also preload retired_count to 2^CNT_W-1 (CNT_W=4: 15); the next retire wraps it to 0.

Source files
------------

// File: rtl/stage_chk_pkg.sv
// stage_chk_pkg: shared stage/state encodings, error codes and strobe bit indices
package stage_chk_pkg;
  typedef enum logic [3:0] {
    ST_INIT = 4'd0, ST_IF = 4'd1, ST_IF_ID = 4'd2, ST_ID = 4'd3, ST_ID_EX = 4'd4,
    ST_EX_MEM = 4'd5, ST_MEM = 4'd6, ST_MEM_WB = 4'd7, ST_WB = 4'd8, ST_WB_IF = 4'd9
  } stage_t;
  typedef enum logic [1:0] {S_UNSYNC, S_INIT, S_TRACK, S_ERROR} state_t;
  localparam logic [2:0] ERR_MULTI = 3'd1;
  localparam logic [2:0] ERR_EXTRA = 3'd2;
  localparam logic [2:0] ERR_MISSING = 3'd3;
  localparam logic [2:0] ERR_PC = 3'd4;
  localparam int B_PC = 7;
  localparam int B_WB_IF = 6;
  localparam int B_IF_ID = 5;
  localparam int B_ID_EX = 4;
  localparam int B_EX_MEM = 3;
  localparam int B_MEM_WB = 2;
  localparam int B_RAM = 1;
  localparam int B_REG = 0;
  function automatic stage_t next_stage(input stage_t s);
    return s == ST_WB_IF ? ST_IF : stage_t'(s + 4'd1);
  endfunction
endpackage

// File: rtl/stage_strobe_expect.sv
// stage_strobe_expect: required non-pc strobe mask and pc permission per expected stage
module stage_strobe_expect
  import stage_chk_pkg::*;
(
  input  stage_t     stage,
  output logic [6:0] mask,
  output logic       pc_ok
);
  assign pc_ok = stage == ST_WB_IF;
  always_comb begin
    mask = '0;
    case (stage)
      ST_IF_ID:  mask[B_IF_ID] = 1'b1;
      ST_ID_EX:  mask[B_ID_EX] = 1'b1;
      ST_EX_MEM: mask[B_EX_MEM] = 1'b1;
      ST_MEM:    mask[B_RAM] = 1'b1;
      ST_MEM_WB: mask[B_MEM_WB] = 1'b1;
      ST_WB:     mask[B_REG] = 1'b1;
      ST_WB_IF:  mask[B_WB_IF] = 1'b1;
      default:   mask = '0;
    endcase
  end
endmodule

// File: rtl/stage_sequence_checker.sv
// stage_sequence_checker: passive monitor of stage-controller strobes with retire count and sticky first error
module stage_sequence_checker
  import stage_chk_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stage_reset_n,
  input  logic             pc_wren,
  input  logic             wb_if_wren,
  input  logic             if_id_wren,
  input  logic             id_ex_wren,
  input  logic             ex_mem_wren,
  input  logic             mem_wb_wren,
  input  logic             ram_wren,
  input  logic             reg_wren,
  input  logic             err_clear,
  output logic             in_sync,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic [3:0]       err_stage
);
  state_t state, state_nx;
  stage_t exp_stage, exp_nx, chk_stage;
  logic [7:0] strobes;
  logic [6:0] np, mask;
  logic pc_ok, checking, err, retire;
  logic [2:0] code;
  assign strobes = {pc_wren, wb_if_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren};
  assign np = strobes[6:0];
  assign in_sync = state == S_TRACK;
  // INIT checks "all zero" while the controller is held, and the release sample as IF
  assign chk_stage = state == S_INIT ? (stage_reset_n ? ST_IF : ST_INIT) : exp_stage;
  stage_strobe_expect u_expect (.stage(chk_stage), .mask(mask), .pc_ok(pc_ok));
  assign code = |(np & (np - 7'd1))        ? ERR_MULTI :
                (strobes[B_PC] && !pc_ok)  ? ERR_PC :
                |(np & ~mask)              ? ERR_EXTRA :
                (|mask && !(|(np & mask))) ? ERR_MISSING : 3'd0;
  assign checking = state == S_INIT || (state == S_TRACK && stage_reset_n);
  assign err = checking && code != 3'd0;
  assign retire = state == S_TRACK && stage_reset_n && exp_stage == ST_WB_IF && !err && !err_clear;
  always_comb begin
    state_nx = state;
    exp_nx = exp_stage;
    if (err_clear) state_nx = S_UNSYNC;
    else if (err) state_nx = S_ERROR;
    else case (state)
      S_INIT: begin
        state_nx = stage_reset_n ? S_TRACK : S_INIT;
        exp_nx = stage_reset_n ? ST_IF_ID : exp_stage;
      end
      S_TRACK: begin
        state_nx = stage_reset_n ? S_TRACK : S_INIT;
        exp_nx = stage_reset_n ? next_stage(exp_stage) : exp_stage;
      end
      default: state_nx = stage_reset_n ? state : S_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_UNSYNC;
      exp_stage <= ST_INIT;
      instr_done <= 1'b0;
      retired_count <= '0;
      cycle_count <= '0;
      err_valid <= 1'b0;
      err_code <= '0;
      err_stage <= '0;
    end else begin
      state <= state_nx;
      exp_stage <= exp_nx;
      instr_done <= retire;
      retired_count <= retired_count + CNT_W'(retire);
      cycle_count <= cycle_count + CNT_W'(in_sync);
      if (err_clear) begin
        err_valid <= 1'b0;
        err_code <= '0;
        err_stage <= '0;
      end else if (err && !err_valid) begin
        err_valid <= 1'b1;
        err_code <= code;
        err_stage <= chk_stage;
      end
    end
  end
endmodule

// File: tb/tb_stage_sequence_checker.sv
// tb_stage_sequence_checker: scoreboarded bench driving strobe sequences against a behavioural model
module tb_stage_sequence_checker;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset_n, stage_reset_n, pc_wren, wb_if_wren, if_id_wren, id_ex_wren;
  logic ex_mem_wren, mem_wb_wren, ram_wren, reg_wren, err_clear;
  logic in_sync, instr_done, err_valid;
  logic [CNT_W-1:0] retired_count, cycle_count;
  logic [2:0] err_code;
  logic [3:0] err_stage;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic sync;
    logic done;
    logic [3:0] ret;
    logic [3:0] cyc;
    logic ev;
    logic [2:0] code;
    logic [3:0] stg;
  } exp_t;
  exp_t sb[$];
  int ms = 0;
  int me = 0;
  logic [3:0] mret = '0, mcyc = '0, mstg = '0;
  logic [2:0] mcode = '0;
  logic mev = 1'b0, mdone = 1'b0;
  always #5 clk = ~clk;
  stage_sequence_checker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .stage_reset_n(stage_reset_n),
    .pc_wren(pc_wren), .wb_if_wren(wb_if_wren), .if_id_wren(if_id_wren),
    .id_ex_wren(id_ex_wren), .ex_mem_wren(ex_mem_wren), .mem_wb_wren(mem_wb_wren),
    .ram_wren(ram_wren), .reg_wren(reg_wren), .err_clear(err_clear),
    .in_sync(in_sync), .instr_done(instr_done), .retired_count(retired_count),
    .cycle_count(cycle_count), .err_valid(err_valid), .err_code(err_code), .err_stage(err_stage)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] req(input int st);
    case (st)
      2: return 8'h20;
      4: return 8'h10;
      5: return 8'h08;
      6: return 8'h02;
      7: return 8'h04;
      8: return 8'h01;
      9: return 8'h40;
      default: return 8'h00;
    endcase
  endfunction
  function automatic int calc(input int st, input logic [7:0] s);
    logic [7:0] r = req(st);
    if ($countones(s[6:0]) > 1) return 1;
    if (s[7] && st != 9) return 4;
    if ((s[6:0] & ~r[6:0]) != 0) return 2;
    if (r != 0 && (s & r) == 0) return 3;
    return 0;
  endfunction
  task automatic step(input logic rn, input logic srn, input logic [7:0] s, input logic clr);
    int stg, c;
    logic trk;
    exp_t e;
    reset_n = rn;
    stage_reset_n = srn;
    {pc_wren, wb_if_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren} = s;
    err_clear = clr;
    trk = ms == 2;
    mdone = 1'b0;
    if (!rn) begin
      ms = 0; me = 0; mret = '0; mcyc = '0; mev = 1'b0; mcode = '0; mstg = '0;
    end else begin
      mcyc = mcyc + 4'(trk);
      stg = ms == 1 ? (srn ? 1 : 0) : me;
      c = (ms == 1 || (ms == 2 && srn)) ? calc(stg, s) : 0;
      if (clr) begin
        ms = 0; mev = 1'b0; mcode = '0; mstg = '0;
      end else if (c != 0) begin
        if (!mev) begin mev = 1'b1; mcode = 3'(c); mstg = 4'(stg); end
        ms = 3;
      end else if (ms == 1) begin
        if (srn) begin ms = 2; me = 2; end
      end else if (ms == 2) begin
        if (!srn) ms = 1;
        else begin
          if (me == 9) begin mdone = 1'b1; mret = mret + 4'd1; end
          me = me == 9 ? 1 : me + 1;
        end
      end else if (!srn) ms = 1;
    end
    sb.push_back('{ms == 2, mdone, mret, mcyc, mev, mcode, mstg});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("in_sync", 32'(in_sync), 32'(e.sync));
    check("instr_done", 32'(instr_done), 32'(e.done));
    check("retired_count", 32'(retired_count), 32'(e.ret));
    check("cycle_count", 32'(cycle_count), 32'(e.cyc));
    check("err_valid", 32'(err_valid), 32'(e.ev));
    check("err_code", 32'(err_code), 32'(e.code));
    check("err_stage", 32'(err_stage), 32'(e.stg));
  endtask
  task automatic seq_run(input int from, input int to);
    for (int st = from; st <= to; st++) step(1'b1, 1'b1, req(st), 1'b0);
  endtask
  initial begin
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("rst_retired", 32'(retired_count), 32'd0);
    check("rst_in_sync", 32'(in_sync), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (4) seq_run(1, 9);
    check("t1_retired", 32'(retired_count), 32'd4);
    check("t1_in_sync", 32'(in_sync), 32'd1);
    check("t1_done", 32'(instr_done), 32'd1);
    check("t1_err_valid", 32'(err_valid), 32'd0);
    check("t1_cycles", 32'(cycle_count), 32'd3);
    seq_run(1, 5);
    step(1'b1, 1'b1, 8'h06, 1'b0);
    check("t2_code", 32'(err_code), 32'd1);
    check("t2_stage", 32'(err_stage), 32'd6);
    repeat (3) step(1'b1, 1'b1, 8'h00, 1'b0);
    check("t2_frozen_retired", 32'(retired_count), 32'd4);
    check("t2_in_sync", 32'(in_sync), 32'd0);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    seq_run(1, 2);
    step(1'b1, 1'b1, 8'h80, 1'b0);
    check("t3_code", 32'(err_code), 32'd4);
    check("t3_stage", 32'(err_stage), 32'd3);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    seq_run(1, 8);
    step(1'b1, 1'b1, 8'hC0, 1'b0);
    check("t3_pc_ok_err", 32'(err_valid), 32'd0);
    check("t3_pc_ok_retired", 32'(retired_count), 32'd5);
    seq_run(1, 7);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    check("t4_code", 32'(err_code), 32'd3);
    check("t4_stage", 32'(err_stage), 32'd8);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    seq_run(1, 9);
    check("t4_resync", 32'(in_sync), 32'd1);
    check("t4_sticky", 32'(err_valid), 32'd1);
    check("t4_retired", 32'(retired_count), 32'd6);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    seq_run(1, 9);
    seq_run(1, 4);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("t5_abort_err", 32'(err_valid), 32'd0);
    check("t5_abort_retired", 32'(retired_count), 32'd1);
    seq_run(1, 9);
    check("t5_retired", 32'(retired_count), 32'd2);
    seq_run(1, 1);
    step(1'b1, 1'b1, 8'hA0, 1'b0);
    check("t6_pending", 32'(err_code), 32'd4);
    step(1'b1, 1'b1, 8'h03, 1'b1);
    check("t6_clr_valid", 32'(err_valid), 32'd0);
    check("t6_clr_code", 32'(err_code), 32'd0);
    step(1'b1, 1'b1, 8'h03, 1'b0);
    check("t6_unsync_nochk", 32'(err_valid), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    check("t6_init_code", 32'(err_code), 32'd2);
    check("t6_init_stage", 32'(err_stage), 32'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (15) seq_run(1, 9);
    check("t6_max", 32'(retired_count), 32'd15);
    seq_run(1, 9);
    check("t6_wrap", 32'(retired_count), 32'd0);
    check("t6_wrap_done", 32'(instr_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
